// File: rtl/sevenseg_scroll_ctrl_pkg.sv
// Shared definitions for the 7-segment message window and its display driver.
package sevenseg_scroll_ctrl_pkg;

  localparam int CHAR_W     = 5;
  localparam int NUM_DIGITS = 8;

  // Code written into digits that hold no character.
  localparam logic [CHAR_W-1:0] BLANK_CODE = 5'd31;

  typedef logic [CHAR_W-1:0] char_t;

  // Window controller sequencing: wait for a tick, then perform one window operation.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    BKSP  = 2'd2
  } state_t;

endpackage

// File: rtl/sevenseg_scroll_ctrl_char_fifo.sv
// Synchronous FIFO for pending characters. Push into a full FIFO and pop from an
// empty one are ignored. Flush empties the FIFO in one cycle.
module char_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full & ~flush;
  assign do_pop   = pop & ~empty & ~flush;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write port.
  // NOTE: the storage array is deliberately not reset; occupancy and pointers
  // alone decide which entries are meaningful, so the data needs no initial value.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sevenseg_scroll_ctrl.sv
// Message-window controller for the 8-digit multiplexed 7-segment array.
// Buffers incoming character codes and, once per scroll tick, either shifts the
// next character in from the right or performs a pending backspace.
module sevenseg_scroll_ctrl
  import sevenseg_scroll_ctrl_pkg::CHAR_W,
         sevenseg_scroll_ctrl_pkg::NUM_DIGITS,
         sevenseg_scroll_ctrl_pkg::char_t,
         sevenseg_scroll_ctrl_pkg::state_t,
         sevenseg_scroll_ctrl_pkg::IDLE,
         sevenseg_scroll_ctrl_pkg::SHIFT,
         sevenseg_scroll_ctrl_pkg::BKSP;
#(
  parameter int                FIFO_DEPTH = 4,
  parameter int                SCROLL_DIV = 12500000,
  parameter logic [CHAR_W-1:0] BLANK_CODE = sevenseg_scroll_ctrl_pkg::BLANK_CODE
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic [CHAR_W-1:0]             iChar,
  input  logic                          iChar_valid,
  output logic                          oChar_ready,
  input  logic                          iBackspace,
  input  logic                          iClear,
  output logic [CHAR_W-1:0]             char0,
  output logic [CHAR_W-1:0]             char1,
  output logic [CHAR_W-1:0]             char2,
  output logic [CHAR_W-1:0]             char3,
  output logic [CHAR_W-1:0]             char4,
  output logic [CHAR_W-1:0]             char5,
  output logic [CHAR_W-1:0]             char6,
  output logic [CHAR_W-1:0]             char7,
  output logic [$clog2(FIFO_DEPTH):0]   oPending,
  output logic                          oBusy
);

  localparam int CNT_W  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int PEND_W = $clog2(FIFO_DEPTH) + 1;

  logic [CNT_W-1:0]  tick_cnt;
  logic              tick;
  state_t            state;
  state_t            state_nxt;
  logic              bs_pend;
  char_t             win [NUM_DIGITS];

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  char_t             fifo_head;
  logic [PEND_W-1:0] fifo_count;

  assign tick = (tick_cnt == CNT_W'(SCROLL_DIV - 1));

  // A push that coincides with a clear is dropped along with the FIFO contents.
  assign oChar_ready = ~fifo_full;
  assign fifo_push   = iChar_valid & oChar_ready & ~iClear;
  assign fifo_pop    = (state == SHIFT) & ~iClear;

  char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CHAR_W)
  ) u_fifo (
    .clk       (iCLK),
    .rst       (iRST),
    .push      (fifo_push),
    .push_data (iChar),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .flush     (iClear),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Free-running scroll pacer; only reset and clear restart it.
  always_ff @(posedge iCLK) begin
    if (iRST || iClear) tick_cnt <= '0;
    else if (tick)      tick_cnt <= '0;
    else                tick_cnt <= tick_cnt + CNT_W'(1);
  end

  // Sequencer state register.
  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state selection: on a tick, a pending backspace beats a pending character.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_nxt = state;
    case (state)
      IDLE: begin
        if (tick) begin
          if (bs_pend)          state_nxt = BKSP;
          else if (!fifo_empty) state_nxt = SHIFT;
        end
      end
      SHIFT:   state_nxt = IDLE;
      BKSP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (iClear) state_nxt = IDLE;
  end

  // Backspace request flag; a new pulse during an executing backspace re-arms it.
  always_ff @(posedge iCLK) begin
    if (iRST || iClear)      bs_pend <= 1'b0;
    else if (iBackspace)     bs_pend <= 1'b1;
    else if (state == BKSP)  bs_pend <= 1'b0;
  end

  // Window shift register: left shift appends the FIFO head, right shift undoes the newest char.
  always_ff @(posedge iCLK) begin
    if (iRST || iClear) begin
      for (int i = 0; i < NUM_DIGITS; i++) win[i] <= BLANK_CODE;
    end else begin
      case (state)
        SHIFT: begin
          for (int i = 0; i < NUM_DIGITS - 1; i++) win[i] <= win[i+1];
          win[NUM_DIGITS-1] <= fifo_head;
        end
        BKSP: begin
          for (int i = 1; i < NUM_DIGITS; i++) win[i] <= win[i-1];
          win[0] <= BLANK_CODE;
        end
        default: ;
      endcase
    end
  end

  assign char0 = win[0];
  assign char1 = win[1];
  assign char2 = win[2];
  assign char3 = win[3];
  assign char4 = win[4];
  assign char5 = win[5];
  assign char6 = win[6];
  assign char7 = win[7];

  assign oPending = fifo_count;
  assign oBusy    = (fifo_count != '0) | bs_pend;

endmodule

// File: tb/tb_sevenseg_scroll_ctrl.sv
// Self-checking bench for sevenseg_scroll_ctrl: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a queue-based model.
module tb_sevenseg_scroll_ctrl;

  localparam int DEPTH = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 31;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic [4:0] iChar = '0;
  logic       iChar_valid = 1'b0;
  logic       oChar_ready;
  logic       iBackspace = 1'b0;
  logic       iClear = 1'b0;
  logic [4:0] char0, char1, char2, char3, char4, char5, char6, char7;
  logic [2:0] oPending;
  logic       oBusy;

  logic [4:0] dut_ch [8];

  int checks   = 0;
  int failures = 0;

  // Reference model: window as an array, pending characters as a queue, and the
  // window operation that was decided on the last tick (0 none, 1 scroll, 2 erase).
  int win [8];
  int q [$];
  bit bs;
  int cnt;
  int op;

  sevenseg_scroll_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .SCROLL_DIV (DIV),
    .BLANK_CODE (5'd31)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iChar       (iChar),
    .iChar_valid (iChar_valid),
    .oChar_ready (oChar_ready),
    .iBackspace  (iBackspace),
    .iClear      (iClear),
    .char0       (char0),
    .char1       (char1),
    .char2       (char2),
    .char3       (char3),
    .char4       (char4),
    .char5       (char5),
    .char6       (char6),
    .char7       (char7),
    .oPending    (oPending),
    .oBusy       (oBusy)
  );

  always #5 iCLK = ~iCLK;

  assign dut_ch[0] = char0;
  assign dut_ch[1] = char1;
  assign dut_ch[2] = char2;
  assign dut_ch[3] = char3;
  assign dut_ch[4] = char4;
  assign dut_ch[5] = char5;
  assign dut_ch[6] = char6;
  assign dut_ch[7] = char7;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_blank();
    for (int i = 0; i < 8; i++) win[i] = BLANK;
    q.delete();
    bs  = 1'b0;
    cnt = 0;
    op  = 0;
  endtask

  // One clock edge of the model, using the inputs the DUT sampled at that edge.
  task automatic model_update();
    int  sz;
    bit  was_bs;
    bit  tick_now;
    int  nop;
    if (iRST || iClear) begin
      model_blank();
      return;
    end
    sz       = q.size();
    was_bs   = bs;
    tick_now = (cnt == DIV - 1);
    if (op == 1) begin
      for (int i = 0; i < 7; i++) win[i] = win[i+1];
      win[7] = q.pop_front();
    end else if (op == 2) begin
      for (int i = 7; i > 0; i--) win[i] = win[i-1];
      win[0] = BLANK;
    end
    if (iChar_valid && sz != DEPTH) q.push_back(int'(iChar));
    if (iBackspace)   bs = 1'b1;
    else if (op == 2) bs = 1'b0;
    nop = 0;
    if (tick_now) nop = was_bs ? 2 : ((sz != 0) ? 1 : 0);
    op  = nop;
    cnt = (cnt + 1) % DIV;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 8; i++) check($sformatf("char%0d", i), 32'(dut_ch[i]), 32'(win[i]));
    check("pending", 32'(oPending), 32'(q.size()));
    check("ready",   32'(oChar_ready), 32'(q.size() != DEPTH));
    check("busy",    32'(oBusy), 32'((q.size() != 0) || bs));
  endtask

  task automatic step();
    @(posedge iCLK);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic pulse_clear();
    iClear = 1'b1;
    step();
    iClear = 1'b0;
  endtask

  // Hold a character on the input until the model says it was taken (bounded).
  task automatic push_code(input int c);
    bit acc = 1'b0;
    iChar       = 5'(c);
    iChar_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      acc = (q.size() != DEPTH);
      step();
      if (acc) break;
    end
    iChar_valid = 1'b0;
    check("push_accept", 32'(acc), 32'd1);
  endtask

  task automatic align_tick_phase();
    for (int k = 0; k < 2 * DIV && cnt != 0; k++) step();
    check("align", 32'(cnt), 32'd0);
  endtask

  initial begin
    model_blank();

    // Reset state.
    iRST = 1'b1;
    step();
    step();
    iRST = 1'b0;
    check("rst_char0", 32'(char0), 32'd31);
    check("rst_char7", 32'(char7), 32'd31);
    check("rst_pending", 32'(oPending), 32'd0);
    check("rst_ready", 32'(oChar_ready), 32'd1);
    check("rst_busy", 32'(oBusy), 32'd0);

    // Three back-to-back pushes scroll in over three ticks.
    for (int c = 1; c <= 3; c++) begin
      iChar = 5'(c);
      iChar_valid = 1'b1;
      step();
    end
    iChar_valid = 1'b0;
    check("t1_pending3", 32'(oPending), 32'd3);
    repeat (16) step();
    check("t1_char5", 32'(char5), 32'd1);
    check("t1_char6", 32'(char6), 32'd2);
    check("t1_char7", 32'(char7), 32'd3);
    check("t1_char0", 32'(char0), 32'd31);
    check("t1_busy", 32'(oBusy), 32'd0);

    // Fill the FIFO; ready drops at full occupancy.
    pulse_clear();
    iChar_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      iChar = 5'(10 + k);
      step();
      if (k == 3) begin
        check("t2_full_pending", 32'(oPending), 32'd4);
        check("t2_full_ready", 32'(oChar_ready), 32'd0);
      end
    end
    iChar_valid = 1'b0;

    // Window 1..8, then two backspaces collapse into one erase before the next scroll.
    pulse_clear();
    for (int c = 1; c <= 8; c++) push_code(c);
    repeat (40) step();
    check("t3_char0_full", 32'(char0), 32'd1);
    check("t3_char7_full", 32'(char7), 32'd8);
    align_tick_phase();
    iBackspace = 1'b1; step(); iBackspace = 1'b0;
    iBackspace = 1'b1; step(); iBackspace = 1'b0;
    iChar = 5'd9; iChar_valid = 1'b1; step(); iChar_valid = 1'b0;
    step();
    step();
    check("t3_bksp_char0", 32'(char0), 32'd31);
    check("t3_bksp_char7", 32'(char7), 32'd7);
    repeat (4) step();
    check("t3_shift_char7", 32'(char7), 32'd9);
    check("t3_shift_char6", 32'(char6), 32'd7);

    // Idle ticks with nothing pending leave the window alone.
    repeat (12) step();
    check("t6_char0", 32'(char0), 32'd1);
    check("t6_char7", 32'(char7), 32'd9);
    check("t6_busy", 32'(oBusy), 32'd0);

    // Clear wins over a simultaneous push, a pending backspace and a tick.
    pulse_clear();
    iChar_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iChar = 5'(20 + k);
      iBackspace = (k == 2);
      step();
    end
    iBackspace = 1'b0;
    check("t4_pre_busy", 32'(oBusy), 32'd1);
    iChar = 5'd23;
    iClear = 1'b1;
    step();
    iClear = 1'b0;
    iChar_valid = 1'b0;
    for (int i = 0; i < 8; i++) check($sformatf("t4_char%0d", i), 32'(dut_ch[i]), 32'd31);
    check("t4_pending", 32'(oPending), 32'd0);
    check("t4_busy", 32'(oBusy), 32'd0);
    step();
    check("t4_pending_after", 32'(oPending), 32'd0);

    // Reset during an executing scroll suppresses the window write.
    pulse_clear();
    iChar = 5'd5; iChar_valid = 1'b1; step(); iChar_valid = 1'b0;
    step();
    step();
    step();
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    check("t5_char7", 32'(char7), 32'd31);
    check("t5_pending", 32'(oPending), 32'd0);
    check("t5_ready", 32'(oChar_ready), 32'd1);
    iChar = 5'd6; iChar_valid = 1'b1; step(); iChar_valid = 1'b0;
    step();
    step();
    step();
    check("t5_before_tick", 32'(char7), 32'd31);
    step();
    check("t5_after_tick", 32'(char7), 32'd6);

    // Randomized traffic, including out-of-range codes, clears, backspaces and resets.
    for (int n = 0; n < 3000; n++) begin
      iChar       = 5'($urandom_range(0, 31));
      iChar_valid = ($urandom_range(0, 99) < 50);
      iBackspace  = ($urandom_range(0, 99) < 6);
      iClear      = ($urandom_range(0, 99) < 2);
      iRST        = ($urandom_range(0, 999) < 5);
      step();
    end
    iChar_valid = 1'b0;
    iBackspace  = 1'b0;
    iClear      = 1'b0;
    iRST        = 1'b0;
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
